// File: rtl/bool_sweep.sv
// Exhaustive sweep of an N-variable input space comparing an unsimplified boolean
// expression against its simplified form, with mismatch counting and first-hit capture.
module bool_sweep #(
  parameter int N       = 3,
  parameter int LOOP_EN = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic         mode,
  input  logic         flt_en,
  input  logic [N-1:0] flt_code,
  output logic [N-1:0] vec,
  output logic         s1,
  output logic         s2,
  output logic         valid,
  output logic         busy,
  output logic         done,
  output logic [N:0]   mism_cnt,
  output logic [N-1:0] first_mism,
  output logic         first_vld
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] VEC_MAX = {N{1'b1}};
  localparam logic [N-1:0] VEC_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]   CNT_MAX = {(N+1){1'b1}};
  localparam logic [N:0]   CNT_ONE = {{N{1'b0}}, 1'b1};

  state_t       state_reg, state_next;
  logic [N-1:0] vec_reg, vec_next;
  logic [N:0]   mism_cnt_reg, mism_cnt_next;
  logic [N-1:0] first_mism_reg, first_mism_next;
  logic         first_vld_reg, first_vld_next;

  logic x, y, mism, loop_mode, at_last;

  assign x = vec_reg[N-1];
  assign y = vec_reg[N-2];

  // Both forms are evaluated on every vec; only RUN cycles are counted.
  assign s1 = x & ~(~x | y);
  assign s2 = (x & ~y) ^ (flt_en & (vec_reg == flt_code));

  assign mism      = (s1 != s2);
  assign loop_mode = (LOOP_EN != 0) & mode;
  assign at_last   = (vec_reg == VEC_MAX);

  assign valid      = (state_reg == RUN);
  assign busy       = (state_reg == RUN);
  assign done       = (state_reg == DONE);
  assign vec        = vec_reg;
  assign mism_cnt   = mism_cnt_reg;
  assign first_mism = first_mism_reg;
  assign first_vld  = first_vld_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      vec_reg        <= '0;
      mism_cnt_reg   <= '0;
      first_mism_reg <= '0;
      first_vld_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      vec_reg        <= vec_next;
      mism_cnt_reg   <= mism_cnt_next;
      first_mism_reg <= first_mism_next;
      first_vld_reg  <= first_vld_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    vec_next        = vec_reg;
    mism_cnt_next   = mism_cnt_reg;
    first_mism_next = first_mism_reg;
    first_vld_next  = first_vld_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next      = RUN;
          vec_next        = '0;
          mism_cnt_next   = '0;
          first_mism_next = '0;
          first_vld_next  = 1'b0;
        end
      end

      RUN: begin
        // The current sample is scored even when abort ends the sweep here.
        if (mism) begin
          if (mism_cnt_reg != CNT_MAX) begin
            mism_cnt_next = mism_cnt_reg + CNT_ONE;
          end
          if (!first_vld_reg) begin
            first_mism_next = vec_reg;
            first_vld_next  = 1'b1;
          end
        end

        if (abort) begin
          state_next = IDLE;
        end else if (at_last) begin
          if (loop_mode) begin
            vec_next = '0;
          end else begin
            state_next = DONE;
          end
        end else begin
          vec_next = vec_reg + VEC_ONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/bool_sweep.md
BOOL_SWEEP -- requirements
Module: bool_sweep

Interface
REQ-001 Parameter N, default 3, number of input variables; legal range 2..8.
REQ-002 Parameter LOOP_EN, default 0: 1 permits the continuous-sweep mode; 0 ties the loop mode off.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  IDLE/DONE: begin a new sweep.
REQ-006 abort  input  1  RUN: terminate the sweep.
REQ-007 mode  input  1  0 single sweep, 1 continuous; effective only when LOOP_EN=1.
REQ-008 flt_en  input  1  fault-inject enable, a verification hook.
REQ-009 flt_code  input  N  combination at which s2 is inverted when flt_en=1.
REQ-010 vec  output  N  current input combination; x=vec[N-1], y=vec[N-2], rest don't-care.
REQ-011 s1  output  1  unsimplified form: x AND NOT(NOT x OR y).
REQ-012 s2  output  1  simplified form: x AND NOT y, XOR (flt_en AND vec==flt_code).
REQ-013 valid  output  1  s1/s2 are a checked sample this cycle.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  high in DONE.
REQ-016 mism_cnt  output  N+1  number of sampled cycles with s1!=s2 in the current sweep.
REQ-017 first_mism  output  N  vec value of the first mismatch in the sweep.
REQ-018 first_vld  output  1  first_mism holds a captured value.

Function
REQ-019 States are IDLE, RUN and DONE; the state and vec are registered.
REQ-020 s1, s2, valid, busy and done are combinational decodes of the registered state, vec, flt_en and flt_code.
REQ-021 valid=1 exactly when the state is RUN.
REQ-022 IDLE + start=1 -> RUN next cycle with vec=0; mism_cnt, first_mism and first_vld are cleared on the same edge.
REQ-023 DONE + start=1 behaves identically to IDLE + start=1.
REQ-024 In RUN, vec increments by 1 every cycle.
REQ-025 A single sweep occupies exactly 2^N RUN cycles, vec 0..2^N-1 in order.
REQ-026 RUN with vec=2^N-1 and effective mode=0 -> DONE next cycle; vec holds 2^N-1.
REQ-027 RUN with vec=2^N-1 and effective mode=1 -> vec wraps to 0, the state stays RUN, and the counters are not cleared.
REQ-028 mism_cnt increments on every RUN cycle with s1!=s2.
REQ-029 mism_cnt saturates at 2^(N+1)-1.
REQ-030 On the first RUN cycle with s1!=s2 while first_vld=0, first_mism<=vec and first_vld<=1.
REQ-031 Once first_vld=1, first_mism holds until the next clear.
REQ-032 RUN + abort=1 -> IDLE next cycle.
REQ-033 The sample on the abort cycle itself is still counted; vec and the counters hold after abort.
REQ-034 abort has priority over end-of-sweep: abort on the vec=2^N-1 cycle -> IDLE, not DONE, no wrap.
REQ-035 start is ignored in RUN.
REQ-036 abort is ignored outside RUN.
REQ-037 DONE holds until start; counters remain readable in IDLE and DONE.
REQ-038 With flt_en=0, s1==s2 for every vec by construction, so mism_cnt stays 0.

Reset
REQ-039 reset=1 at a clock edge -> state=IDLE, vec=0, mism_cnt=0, first_mism=0, first_vld=0.
REQ-040 Resulting outputs after reset: valid=0, busy=0, done=0.
REQ-041 reset has priority over start and abort.
REQ-042 A reset asserted mid-sweep discards the sweep with no DONE pulse.
REQ-043 The first sweep can start on the cycle after reset deasserts.

Verification
REQ-044 N=3, flt_en=0, pulse start -> busy for 8 cycles, vec 0..7, s1=s2=(vec[2]&~vec[1]), i.e. 1 at vec=4,5; then done=1, mism_cnt=0, first_vld=0.
REQ-045 N=3, flt_en=1, flt_code=3'b110 -> mism_cnt=1, first_mism=6, first_vld=1, done after 8 cycles.
REQ-046 N=3, abort at vec=3 -> IDLE next cycle, vec=3, done never asserted; a new start restarts at vec=0 with counters cleared.
REQ-047 LOOP_EN=1, mode=1, N=2, flt_en=1, flt_code=1, run 12 cycles then abort -> vec wrapped 3->0 twice, mism_cnt=3, first_mism=1.
REQ-048 Reset asserted at vec=5 mid-sweep -> next cycle IDLE, vec=0, all counters 0.
REQ-049 Start asserted while busy -> no effect on sequence or counters.
